// File: rtl/inv_shift_rows_buf_if.sv
// Purpose: valid/ready bundle carrying AES states into and out of the InvShiftRows stage.
// Latency: none; this is wiring only.
// Backpressure: in_ready / out_ready are the two flow-control returns.
interface inv_shift_rows_buf_if #(
  parameter int DW = 128
);
  logic          in_valid;
  logic          in_ready;
  logic [0:DW-1] Data;
  logic          out_valid;
  logic          out_ready;
  logic [0:DW-1] Shifted_Data;

  // Upstream/downstream agent: drives the input state and accepts output
  modport master (
    output in_valid, Data, out_ready,
    input  in_ready, out_valid, Shifted_Data
  );

  // The stage itself
  modport slave (
    input  in_valid, Data, out_ready,
    output in_ready, out_valid, Shifted_Data
  );
endinterface

// File: rtl/inv_shift_rows_buf.sv
// Purpose: AES InvShiftRows (row r rotated right by r bytes) feeding a 2-entry output FIFO.
// Latency: 1 cycle from input acceptance to Shifted_Data when the buffer is empty.
// Backpressure: in_ready drops only when both entries are full; en low freezes and masks both sides.
module inv_shift_rows_buf #(
  parameter int word_size  = 8,   // only 8 is supported
  parameter int array_size = 16,  // only 16 is supported
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  inv_shift_rows_buf_if.slave bus,
  output logic [CNT_W-1:0] blk_count
);

  localparam int DW = word_size * array_size;

  // Byte k holds state[r][c] with k = 4*c + r; output byte k takes input
  // state[r][(c - r) mod 4].
  function automatic int src_byte(input int k);
    int r;
    int c;
    r = k % 4;
    c = k / 4;
    return 4 * ((c - r + 4) % 4) + r;
  endfunction

  logic [0:DW-1]    shifted;
  logic [0:DW-1]    mem_q [2];
  logic [0:DW-1]    mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;
  logic             pop;

  // Handshake outputs come from registered occupancy and en only, so
  // in_ready never loops back through in_valid or out_ready.
  assign bus.in_ready     = en && (occ_q != 2'd2);
  assign bus.out_valid    = en && (occ_q != 2'd0);
  assign bus.Shifted_Data = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign blk_count        = cnt_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Inverse row shift: a pure byte permutation of the incoming state
  always_comb begin
    shifted = '0;
    for (int k = 0; k < array_size; k++) begin
      shifted[k*word_size +: word_size] = bus.Data[src_byte(k)*word_size +: word_size];
    end
  end

  // Next-state for the FIFO pointers, occupancy, contents and block counter
  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = shifted;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards any buffered states
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; unreset since contents are hidden while occ is zero
  always_ff @(posedge clk) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

endmodule

// File: tb/tb_inv_shift_rows_buf.sv
// Purpose: self-checking bench for inv_shift_rows_buf against a queue-based reference model.
// Latency: model advances one entry per clock edge, mirroring the accept/pop rules.
// Backpressure: stimulus toggles en, in_valid and out_ready to exercise full/empty/frozen cases.
module tb_inv_shift_rows_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] blk_count;

  inv_shift_rows_buf_if #(.DW(128)) bus ();

  inv_shift_rows_buf #(
    .word_size (8),
    .array_size(16),
    .CNT_W     (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: queue of expected output states plus a pop counter
  logic [0:127] mq[$];
  logic [15:0]  mcnt = 16'd0;

  // InvShiftRows on a 4x4 byte matrix: out[r][c] = in[r][(c - r) mod 4]
  function automatic logic [0:127] ref_isr(input logic [0:127] d);
    logic [7:0]   s [4][4];
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = d[(4*c + r)*8 +: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[(4*c + r)*8 +: 8] = s[r][(c - r + 4) % 4];
    return o;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: update the model from the inputs presented this cycle
  task automatic tick();
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      mcnt = 16'd0;
    end else begin
      do_pop  = en && (mq.size() > 0) && bus.out_ready;
      do_push = en && bus.in_valid && (mq.size() < 2);
      if (do_pop) begin
        void'(mq.pop_front());
        mcnt = mcnt + 16'd1;
      end
      if (do_push) mq.push_back(ref_isr(bus.Data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Data = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.Shifted_Data !== 128'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", bus.Shifted_Data); end
    checks++; if (blk_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %h expected 0", blk_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_known_vector();
    logic [0:127] exp_v;
    exp_v = 128'h000d0a07_04010e0b_0805020f_0c090603;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.Data      = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL kv_out_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.Shifted_Data !== exp_v) begin failures++; $display("FAIL kv_data: got %h expected %h", bus.Shifted_Data, exp_v); end
    tick();
    checks++; if (blk_count !== 16'd1) begin failures++; $display("FAIL kv_count: got %h expected 1", blk_count); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL kv_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_round_trip();
    logic [0:127] exp_v;
    exp_v = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.Data      = 128'h00050a0f_04090e03_080d0207_0c01060b;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.Shifted_Data !== exp_v) begin failures++; $display("FAIL round_trip: got %h expected %h", bus.Shifted_Data, exp_v); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [0:127] a, b, c;
    logic [0:127] exp_list [3];
    logic [0:127] got [$];
    logic [15:0]  base;
    bit           acc;
    a = rand_state(); b = rand_state(); c = rand_state();
    exp_list[0] = ref_isr(a); exp_list[1] = ref_isr(b); exp_list[2] = ref_isr(c);
    base = mcnt;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Data = a; tick();
    bus.Data = b; tick();
    bus.Data = c;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.Shifted_Data !== exp_list[0]) begin failures++; $display("FAIL bp_head: got %h expected %h", bus.Shifted_Data, exp_list[0]); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_ready: got %b expected 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.Shifted_Data);
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) bus.in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      failures++; $display("FAIL bp_pop_count: got %0d expected 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got[i] !== exp_list[i]) begin failures++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], exp_list[i]); end
      end
    end
    checks++; if (blk_count !== base + 16'd3) begin failures++; $display("FAIL bp_count: got %h expected %h", blk_count, base + 16'd3); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Data      = rand_state();
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.Data = rand_state();
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.Shifted_Data !== mq[0]) begin failures++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.Shifted_Data, mq[0]); end
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++; if (blk_count !== mcnt) begin failures++; $display("FAIL b2b_count: got %h expected %h", blk_count, mcnt); end
  endtask

  task automatic test_en_gap();
    logic [0:127] e0, e1;
    logic [0:127] got [$];
    logic [15:0]  base;
    e0 = rand_state(); e1 = rand_state();
    base = mcnt;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Data = e0; tick();
    bus.Data = e1; tick();
    en = 1'b0;
    bus.out_ready = 1'b1;
    bus.Data = rand_state();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL gap_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL gap_out_valid[%0d]: got %b expected 0", i, bus.out_valid); end
      checks++; if (bus.Shifted_Data !== ref_isr(e0)) begin failures++; $display("FAIL gap_head[%0d]: got %h expected %h", i, bus.Shifted_Data, ref_isr(e0)); end
      checks++; if (blk_count !== base) begin failures++; $display("FAIL gap_count[%0d]: got %h expected %h", i, blk_count, base); end
      tick();
    end
    en = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.Shifted_Data);
      tick();
    end
    checks++;
    if (got.size() != 2) begin
      failures++; $display("FAIL gap_pop_count: got %0d expected 2", got.size());
    end else begin
      checks++; if (got[0] !== ref_isr(e0)) begin failures++; $display("FAIL gap_first: got %h expected %h", got[0], ref_isr(e0)); end
      checks++; if (got[1] !== ref_isr(e1)) begin failures++; $display("FAIL gap_second: got %h expected %h", got[1], ref_isr(e1)); end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.Data = rand_state(); tick();
    bus.Data = rand_state(); tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_full: got %b expected 0", bus.in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.Shifted_Data !== 128'h0) begin failures++; $display("FAIL mid_data: got %h expected 0", bus.Shifted_Data); end
    checks++; if (blk_count !== 16'd0) begin failures++; $display("FAIL mid_count: got %h expected 0", blk_count); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_random();
    logic [0:127] exp_d;
    for (int i = 0; i < 400; i++) begin
      en            = ($urandom_range(0, 7) != 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.Data      = rand_state();
      #1;
      exp_d = (mq.size() > 0) ? mq[0] : 128'h0;
      checks++; if (bus.in_ready !== (en && mq.size() < 2)) begin failures++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, bus.in_ready, en && mq.size() < 2); end
      checks++; if (bus.out_valid !== (en && mq.size() > 0)) begin failures++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", i, bus.out_valid, en && mq.size() > 0); end
      checks++; if (bus.Shifted_Data !== exp_d) begin failures++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, bus.Shifted_Data, exp_d); end
      checks++; if (blk_count !== mcnt) begin failures++; $display("FAIL rnd_count[%0d]: got %h expected %h", i, blk_count, mcnt); end
      tick();
    end
    en = 1'b1;
  endtask

  task automatic test_wrap();
    int n;
    en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (mcnt != 16'hFFFF && n < 70000) begin
      bus.Data = rand_state();
      tick();
      n++;
    end
    #1;
    checks++; if (blk_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_max: got %h expected ffff", blk_count); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid: got %b expected 1", bus.out_valid); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (blk_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h expected 0000", blk_count); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Data = '0;
    test_reset();
    test_known_vector();
    test_round_trip();
    test_backpressure();
    test_back_to_back();
    test_en_gap();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
